seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, registered successor to the CPU's combinational ALU.
- Executes one micro-op at a time using a valid/ready handshake on both sides.
- Holds the NZCV flags in an architectural register.
- Adds iterative MUL, ASR, ARM-correct carry semantics and a flush input; sits between the decode stage and register writeback.

Parameters:
WIDTH, 32, datapath width in bits; power of two, 8 to 64.
SHW, $clog2(WIDTH)+1, number of low rhs bits used as the shift amount.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous abort of the in-flight op
in_valid  in  1  operation offered
in_ready  out  1  block can accept an operation
uop  in  5  micro-op code: NOP, ADD, SUB, AND, EOR, CMP, LSL, LSR, MOV, STR, LDR from the Utilities package, plus the new MUL and ASR constants added to Utilities
lhs  in  WIDTH  left operand
rhs  in  WIDTH  right operand or shift amount
out_valid  out  1  result available
out_ready  in  1  consumer takes the result
out_result  out  WIDTH  registered result
out_wr  out  1  result must be written back; 0 for CMP, NOP and unknown codes
flags_out  out  4  {N,Z,C,V} flag register
busy  out  1  high in BUSY state

Behaviour:
- Reset (async, rst=1): state=IDLE, in_ready=1 after release, out_valid=0, out_result=0, out_wr=0, flags_out=4'b0000, busy=0. Any in-flight MUL is discarded.
- States: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On in_valid, the op is accepted at the clock edge. MUL goes to BUSY. Every other op computes, registers its result and flags, and goes to DONE, so out_valid rises 1 cycle after acceptance.
  - BUSY: shift-add multiply, one multiplier bit per cycle, WIDTH cycles, then DONE. For MUL, out_valid rises WIDTH+1 cycles after acceptance. in_ready=0.
  - DONE: out_valid=1. out_result, out_wr and flags_out stay stable until out_ready=1.
  - DONE with out_ready=1 and in_valid=1: the new op is accepted on the same edge (back-to-back, no bubble). If only out_ready=1, go to IDLE.
  - in_ready = (state==IDLE) or (state==DONE and out_ready).
- flush: highest priority after rst. Goes to IDLE and clears out_valid. flags_out is unchanged and the in-flight result is lost. An in_valid in the same cycle as flush is not accepted.
- Flag update: flags_out is written on the same edge that out_valid rises.
- Arithmetic, computed at WIDTH+1 bits:
  - ADD: {C,res} = lhs+rhs. V = signs of lhs and rhs equal and res sign differs.
  - SUB, CMP: res = lhs-rhs. C = 1 when lhs >= rhs unsigned (ARM not-borrow). V = signs of lhs and rhs differ and res sign differs from lhs. CMP has out_wr=0 but still presents res.
  - AND, EOR, MOV: C and V unchanged. MOV result is rhs.
  - Shifts: amount s = rhs[SHW-1:0].
    - s=0: res=lhs, C unchanged.
    - 0 < s < WIDTH: C = last bit shifted out.
    - s >= WIDTH: LSL/LSR give res=0; ASR gives WIDTH copies of lhs[MSB].
    - For s >= WIDTH, C = lhs[0] for LSL at s==WIDTH, lhs[MSB] for LSR/ASR at s==WIDTH, and for ASR at any s > WIDTH; otherwise 0.
    - V unchanged.
  - MUL: low WIDTH bits of the unsigned product. C and V unchanged.
  - N = res[MSB] and Z = (res==0) for every flag-setting op above.
  - STR, LDR: res = lhs+rhs (address), out_wr=1, flags unchanged.
  - NOP and unknown codes: 1-cycle latency, res=0, out_wr=0, flags unchanged.
- Operands are latched at acceptance; lhs, rhs and uop may change freely afterwards.

Test Plan:
- ADD 0xFFFFFFFF+0x00000001 -> out_result=0x00000000, NZCV=0110, out_valid exactly 1 cycle after accept. Then ADD 0x7FFFFFFF+1 -> 0x80000000, NZCV=1001.
- SUB 5-7 -> 0xFFFFFFFE, NZCV=1000, out_wr=1. CMP 7,7 -> NZCV=0110, out_wr=0.
- LSR 0x3 by 1 -> 0x1 with C=1. LSL 0x1 by 40 -> 0, C=0. ASR 0x80000000 by 35 -> 0xFFFFFFFF, C=1. LSL by 0 preserves the prior C.
- MUL 0x00010000*0x00010000 -> 0x00000000, Z=1, out_valid exactly 33 cycles after accept, busy=1 for 32 cycles. MUL 7*6 -> 42.
- Hold out_ready=0 for 3 cycles in DONE -> outputs stable, in_ready=0. Then out_ready=1 with a new in_valid -> accepted the same cycle, next result 1 cycle later.
- Assert flush at cycle 10 of a MUL -> IDLE next cycle, no out_valid, flags unchanged. Repeat with rst mid-MUL -> all outputs at reset values immediately, before the next edge.

Source files
------------

// File: rtl/seq_alu_if.sv
// Handshake bus between decode, the sequential ALU and writeback.
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       uop;
  logic [WIDTH-1:0] lhs;
  logic [WIDTH-1:0] rhs;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_wr;
  logic [3:0]       flags_out;
  logic             busy;

  // Decode / writeback side: offers ops and consumes results.
  modport master (
    output in_valid, uop, lhs, rhs, out_ready,
    input  in_ready, out_valid, out_result, out_wr, flags_out, busy
  );

  // ALU side.
  modport slave (
    input  in_valid, uop, lhs, rhs, out_ready,
    output in_ready, out_valid, out_result, out_wr, flags_out, busy
  );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ops, iterative shift-add MUL, NZCV flag
// register, valid/ready on both sides and a synchronous flush.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH) + 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  seq_alu_if.slave   bus
);

  localparam int CW  = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  localparam logic [4:0] UOP_NOP = 5'd0;
  localparam logic [4:0] UOP_ADD = 5'd1;
  localparam logic [4:0] UOP_SUB = 5'd2;
  localparam logic [4:0] UOP_AND = 5'd3;
  localparam logic [4:0] UOP_EOR = 5'd4;
  localparam logic [4:0] UOP_CMP = 5'd5;
  localparam logic [4:0] UOP_LSL = 5'd6;
  localparam logic [4:0] UOP_LSR = 5'd7;
  localparam logic [4:0] UOP_MOV = 5'd8;
  localparam logic [4:0] UOP_STR = 5'd9;
  localparam logic [4:0] UOP_LDR = 5'd10;
  localparam logic [4:0] UOP_MUL = 5'd11;
  localparam logic [4:0] UOP_ASR = 5'd12;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] res_q;
  logic             wr_q;
  logic [3:0]       flags_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [CW-1:0]    cnt_q;

  logic             in_ready_s;
  logic             out_valid_s;
  logic             busy_s;
  logic             accept_s;
  logic             mul_last_s;

  logic [WIDTH-1:0] res_d;
  logic             wr_d;
  logic [3:0]       flags_d;
  logic [WIDTH-1:0] acc_d;

  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   diff_s;
  logic [WIDTH:0]   lsl_ext_s;
  logic [WIDTH:0]   lsr_ext_s;
  logic [WIDTH:0]   asr_ext_s;
  logic [SHW-1:0]   shamt_s;
  logic             c_s;
  logic             v_s;
  logic             nz_upd_s;

  // A new op is taken only when ready and no flush is pending.
  assign accept_s   = bus.in_valid & in_ready_s & ~flush;
  assign mul_last_s = (cnt_q == CW'(WIDTH - 1));

  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = out_valid_s;
  assign bus.busy       = busy_s;
  assign bus.out_result = res_q;
  assign bus.out_wr     = wr_q;
  assign bus.flags_out  = flags_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush overrides everything but reset.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_s) begin
            state_d = (bus.uop == UOP_MUL) ? S_BUSY : S_DONE;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_BUSY: begin
          if (mul_last_s) begin
            state_d = S_DONE;
          end else begin
            state_d = S_BUSY;
          end
        end
        S_DONE: begin
          if (accept_s) begin
            state_d = (bus.uop == UOP_MUL) ? S_BUSY : S_DONE;
          end else if (bus.out_ready) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    busy_s      = 1'b0;
    case (state_q)
      S_IDLE: in_ready_s = 1'b1;
      S_BUSY: busy_s = 1'b1;
      S_DONE: begin
        out_valid_s = 1'b1;
        in_ready_s  = bus.out_ready;
      end
      default: in_ready_s = 1'b0;
    endcase
  end

  // Single-cycle datapath: result, write-back enable and next flags.
  always_comb begin
    sum_s     = {1'b0, bus.lhs} + {1'b0, bus.rhs};
    diff_s    = {1'b0, bus.lhs} - {1'b0, bus.rhs};
    shamt_s   = bus.rhs[SHW-1:0];
    // Extra bit catches the last bit shifted out (carry for shifts).
    lsl_ext_s = {1'b0, bus.lhs} << shamt_s;
    lsr_ext_s = {bus.lhs, 1'b0} >> shamt_s;
    asr_ext_s = $signed({bus.lhs, 1'b0}) >>> shamt_s;
    res_d     = {WIDTH{1'b0}};
    wr_d      = 1'b0;
    c_s       = flags_q[1];
    v_s       = flags_q[0];
    nz_upd_s  = 1'b0;
    case (bus.uop)
      UOP_ADD: begin
        res_d    = sum_s[MSB:0];
        c_s      = sum_s[WIDTH];
        v_s      = (bus.lhs[MSB] == bus.rhs[MSB]) && (sum_s[MSB] != bus.lhs[MSB]);
        wr_d     = 1'b1;
        nz_upd_s = 1'b1;
      end
      UOP_SUB, UOP_CMP: begin
        res_d    = diff_s[MSB:0];
        c_s      = ~diff_s[WIDTH];
        v_s      = (bus.lhs[MSB] != bus.rhs[MSB]) && (diff_s[MSB] != bus.lhs[MSB]);
        wr_d     = (bus.uop == UOP_SUB);
        nz_upd_s = 1'b1;
      end
      UOP_AND: begin
        res_d    = bus.lhs & bus.rhs;
        wr_d     = 1'b1;
        nz_upd_s = 1'b1;
      end
      UOP_EOR: begin
        res_d    = bus.lhs ^ bus.rhs;
        wr_d     = 1'b1;
        nz_upd_s = 1'b1;
      end
      UOP_MOV: begin
        res_d    = bus.rhs;
        wr_d     = 1'b1;
        nz_upd_s = 1'b1;
      end
      UOP_LSL: begin
        res_d    = lsl_ext_s[MSB:0];
        if (shamt_s != {SHW{1'b0}}) begin
          c_s = lsl_ext_s[WIDTH];
        end else begin
          c_s = flags_q[1];
        end
        wr_d     = 1'b1;
        nz_upd_s = 1'b1;
      end
      UOP_LSR: begin
        res_d    = lsr_ext_s[WIDTH:1];
        if (shamt_s != {SHW{1'b0}}) begin
          c_s = lsr_ext_s[0];
        end else begin
          c_s = flags_q[1];
        end
        wr_d     = 1'b1;
        nz_upd_s = 1'b1;
      end
      UOP_ASR: begin
        res_d    = asr_ext_s[WIDTH:1];
        if (shamt_s != {SHW{1'b0}}) begin
          c_s = asr_ext_s[0];
        end else begin
          c_s = flags_q[1];
        end
        wr_d     = 1'b1;
        nz_upd_s = 1'b1;
      end
      UOP_STR, UOP_LDR: begin
        res_d = sum_s[MSB:0];
        wr_d  = 1'b1;
      end
      UOP_NOP: begin
        res_d = {WIDTH{1'b0}};
        wr_d  = 1'b0;
      end
      default: begin
        res_d = {WIDTH{1'b0}};
        wr_d  = 1'b0;
      end
    endcase
    if (nz_upd_s) begin
      flags_d = {res_d[MSB], (res_d == {WIDTH{1'b0}}), c_s, v_s};
    end else begin
      flags_d = flags_q;
    end
  end

  // One shift-add multiply step: add multiplicand when the multiplier LSB is set.
  always_comb begin
    if (mplier_q[0]) begin
      acc_d = acc_q + mcand_q;
    end else begin
      acc_d = acc_q;
    end
  end

  // Result, flag and multiplier registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q    <= {WIDTH{1'b0}};
      wr_q     <= 1'b0;
      flags_q  <= 4'b0000;
      mcand_q  <= {WIDTH{1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      acc_q    <= {WIDTH{1'b0}};
      cnt_q    <= {CW{1'b0}};
    end else if (flush) begin
      // In-flight work is abandoned; flags are architectural and kept.
      cnt_q <= {CW{1'b0}};
    end else if (accept_s) begin
      if (bus.uop == UOP_MUL) begin
        mcand_q  <= bus.lhs;
        mplier_q <= bus.rhs;
        acc_q    <= {WIDTH{1'b0}};
        cnt_q    <= {CW{1'b0}};
      end else begin
        res_q   <= res_d;
        wr_q    <= wr_d;
        flags_q <= flags_d;
      end
    end else if (state_q == S_BUSY) begin
      acc_q    <= acc_d;
      mcand_q  <= {mcand_q[WIDTH-2:0], 1'b0};
      mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
      cnt_q    <= cnt_q + CW'(1);
      if (mul_last_s) begin
        res_q   <= acc_d;
        wr_q    <= 1'b1;
        flags_q <= {acc_d[MSB], (acc_d == {WIDTH{1'b0}}), flags_q[1:0]};
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=32).
module tb_seq_alu;

  localparam logic [4:0] UOP_ADD = 5'd1;
  localparam logic [4:0] UOP_SUB = 5'd2;
  localparam logic [4:0] UOP_EOR = 5'd4;
  localparam logic [4:0] UOP_CMP = 5'd5;
  localparam logic [4:0] UOP_LSL = 5'd6;
  localparam logic [4:0] UOP_LSR = 5'd7;
  localparam logic [4:0] UOP_MUL = 5'd11;
  localparam logic [4:0] UOP_ASR = 5'd12;

  logic clk;
  logic rst;
  logic flush;
  int   n_tests;
  int   n_fail;
  int   lat;
  int   bcnt;

  seq_alu_if #(.WIDTH(32)) bus ();

  seq_alu #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if it mismatches.
  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offer one op from IDLE, return cycles to out_valid and busy-cycle count.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int latency, output int busy_cycles);
    bus.uop      = op;
    bus.lhs      = a;
    bus.rhs      = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.lhs      = 32'hDEAD_BEEF;
    bus.rhs      = 32'h1234_5678;
    bus.uop      = 5'd0;
    latency      = 1;
    busy_cycles  = 0;
    while (!bus.out_valid && latency < 100) begin
      if (bus.busy) busy_cycles++;
      @(posedge clk);
      #1;
      latency++;
    end
  endtask

  // Consume the pending result.
  task automatic take(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check_eq(tag, {63'd0, bus.out_valid}, 64'd0);
  endtask

  // Run an op and check latency, result, flags and write-back.
  task automatic op_check(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res,
                          input logic [3:0] exp_flags, input logic exp_wr);
    run_op(op, a, b, lat, bcnt);
    check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, "_res"}, {32'd0, bus.out_result}, {32'd0, exp_res});
    check_eq({tag, "_nzcv"}, {60'd0, bus.flags_out}, {60'd0, exp_flags});
    check_eq({tag, "_wr"}, {63'd0, bus.out_wr}, {63'd0, exp_wr});
    take({tag, "_drain"});
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    rst           = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.uop       = 5'd0;
    bus.lhs       = 32'd0;
    bus.rhs       = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", {63'd0, bus.out_valid}, 64'd0);
    check_eq("rst_result", {32'd0, bus.out_result}, 64'd0);
    check_eq("rst_flags", {60'd0, bus.flags_out}, 64'd0);
    check_eq("rst_busy", {63'd0, bus.busy}, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);

    // Arithmetic and carry/overflow corners.
    op_check("add_wrap", UOP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1, 32'h0000_0000, 4'b0110, 1'b1);
    op_check("add_ovf",  UOP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1, 32'h8000_0000, 4'b1001, 1'b1);
    op_check("sub_neg",  UOP_SUB, 32'd5, 32'd7, 1, 32'hFFFF_FFFE, 4'b1000, 1'b1);
    op_check("cmp_eq",   UOP_CMP, 32'd7, 32'd7, 1, 32'h0000_0000, 4'b0110, 1'b0);

    // Shifts, including out-of-range amounts and a zero shift.
    op_check("lsr_1",    UOP_LSR, 32'h3, 32'd1, 1, 32'h1, 4'b0010, 1'b1);
    op_check("lsl_40",   UOP_LSL, 32'h1, 32'd40, 1, 32'h0, 4'b0100, 1'b1);
    op_check("asr_35",   UOP_ASR, 32'h8000_0000, 32'd35, 1, 32'hFFFF_FFFF, 4'b1010, 1'b1);
    op_check("lsl_0",    UOP_LSL, 32'h5, 32'd0, 1, 32'h5, 4'b0010, 1'b1);

    // Iterative multiply.
    run_op(UOP_MUL, 32'h0001_0000, 32'h0001_0000, lat, bcnt);
    check_eq("mul_lat", 64'(lat), 64'd33);
    check_eq("mul_busy", 64'(bcnt), 64'd32);
    check_eq("mul_res", {32'd0, bus.out_result}, 64'd0);
    check_eq("mul_nzcv", {60'd0, bus.flags_out}, {60'd0, 4'b0110});
    take("mul_drain");
    op_check("mul_76", UOP_MUL, 32'd7, 32'd6, 33, 32'd42, 4'b0010, 1'b1);

    // Back-pressure in DONE, then back-to-back accept.
    run_op(UOP_ADD, 32'd2, 32'd3, lat, bcnt);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_eq("hold_valid", {63'd0, bus.out_valid}, 64'd1);
      check_eq("hold_res", {32'd0, bus.out_result}, 64'd5);
      check_eq("hold_in_ready", {63'd0, bus.in_ready}, 64'd0);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.uop       = UOP_EOR;
    bus.lhs       = 32'hFFFF_FFFF;
    bus.rhs       = 32'h0000_000F;
    #1;
    check_eq("b2b_in_ready", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check_eq("b2b_valid", {63'd0, bus.out_valid}, 64'd1);
    check_eq("b2b_res", {32'd0, bus.out_result}, 64'hFFFF_FFF0);
    check_eq("b2b_nzcv", {60'd0, bus.flags_out}, {60'd0, 4'b1000});
    take("b2b_drain");

    // Flush on cycle 10 of a MUL, with a competing in_valid.
    bus.uop      = UOP_MUL;
    bus.lhs      = 32'd3;
    bus.rhs      = 32'd5;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check_eq("flush_pre_busy", {63'd0, bus.busy}, 64'd1);
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    bus.uop      = UOP_ADD;
    bus.lhs      = 32'd1;
    bus.rhs      = 32'd1;
    @(posedge clk);
    #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    check_eq("flush_busy", {63'd0, bus.busy}, 64'd0);
    check_eq("flush_valid", {63'd0, bus.out_valid}, 64'd0);
    check_eq("flush_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check_eq("flush_flags", {60'd0, bus.flags_out}, {60'd0, 4'b1000});
    repeat (3) @(posedge clk);
    #1;
    check_eq("flush_no_result", {63'd0, bus.out_valid}, 64'd0);

    // Asynchronous reset in the middle of a MUL.
    bus.uop      = UOP_MUL;
    bus.lhs      = 32'd9;
    bus.rhs      = 32'd9;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("arst_busy", {63'd0, bus.busy}, 64'd0);
    check_eq("arst_valid", {63'd0, bus.out_valid}, 64'd0);
    check_eq("arst_result", {32'd0, bus.out_result}, 64'd0);
    check_eq("arst_wr", {63'd0, bus.out_wr}, 64'd0);
    check_eq("arst_flags", {60'd0, bus.flags_out}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    op_check("post_rst_add", UOP_ADD, 32'd1, 32'd1, 1, 32'd2, 4'b0000, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
